// File: rtl/regfile_port_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_port_sequencer                                        |
// | Purpose  : shares the single register-file port between writeback and    |
// |            serialised rs1/rs2 operand reads. Optional macro              |
// |            RFSEQ_DUP_READ_EN folds rs1==rs2 into a single read.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module regfile_port_sequencer #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_op1,
  output logic [XLEN-1:0] rsp_op2,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [4:0]      rf_reg_num,
  output logic            rf_write,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata
);

  localparam int                c_cnt_w      = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [XLEN-1:0]     r_op1;
  logic [XLEN-1:0]     r_op2;
  logic [c_cnt_w-1:0]  r_starve_cnt;

  logic                w_rd_phase;
  logic [4:0]          w_cur_rs;
  logic                w_rs_zero;
  logic                w_wb_ready;
  logic                w_wb_grant;
  logic                w_advance;
  logic                w_do_read;
  logic [XLEN-1:0]     w_rd_val;
  logic                w_dup_hit;

  assign w_rd_phase = (r_state == RD1) || (r_state == RD2);
  assign w_cur_rs   = (r_state == RD1) ? r_rs1 : r_rs2;
  assign w_rs_zero  = (w_cur_rs == 5'd0);
  assign w_rd_val   = w_rs_zero ? '0 : rf_rdata;

`ifdef RFSEQ_DUP_READ_EN
  assign w_dup_hit = (r_rs1 == r_rs2);
`else
  assign w_dup_hit = 1'b0;
`endif

  // An x0 operand never needs the port, so writeback is free that cycle.
  always_comb begin
    w_wb_ready = 1'b0;
    if (resetn) begin
      if (w_rd_phase && !w_rs_zero)
        w_wb_ready = (r_starve_cnt < c_starve_max);
      else
        w_wb_ready = 1'b1;
    end
  end

  assign w_wb_grant = wb_valid && w_wb_ready;
  assign w_advance  = w_rd_phase && (w_rs_zero || !w_wb_grant);
  assign w_do_read  = w_rd_phase && !w_rs_zero && !w_wb_grant;

  always_comb begin
    rf_write   = 1'b0;
    rf_reg_num = 5'd0;
    rf_wdata   = '0;
    if (w_wb_grant) begin
      rf_write   = (wb_rd != 5'd0);
      rf_reg_num = wb_rd;
      rf_wdata   = wb_data;
    end else if (w_do_read) begin
      rf_reg_num = w_cur_rs;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = RD1;
      RD1:     if (w_advance) w_state_nxt = w_dup_hit ? RESP : RD2;
      RD2:     if (w_advance) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == IDLE && req_valid) begin
        r_rs1 <= req_rs1;
        r_rs2 <= req_rs2;
      end

      if (r_state == RD1 && w_advance) begin
        r_op1 <= w_rd_val;
        if (w_dup_hit)
          r_op2 <= w_rd_val;
      end else if (r_state == RD2 && w_advance) begin
        r_op2 <= w_rd_val;
      end

      // Writes landing after an operand was captured are forwarded into it.
      if (w_wb_grant && wb_rd != 5'd0) begin
        if ((r_state == RD2 || r_state == RESP) && wb_rd == r_rs1)
          r_op1 <= wb_data;
        if (r_state == RESP && wb_rd == r_rs2)
          r_op2 <= wb_data;
      end

      if (r_state == IDLE || w_do_read)
        r_starve_cnt <= '0;
      else if (w_rd_phase && w_wb_grant && r_starve_cnt != c_starve_max)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign req_ready = resetn && (r_state == IDLE);
  assign rsp_valid = resetn && (r_state == RESP);
  assign wb_ready  = w_wb_ready;
  assign rsp_op1   = r_op1;
  assign rsp_op2   = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_port_sequencer                                     |
// | Purpose  : directed self-checking bench with a behavioural 32x64 regfile.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_port_sequencer;

  localparam int XLEN         = 64;
  localparam int STARVE_LIMIT = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            req_valid, req_ready;
  logic [4:0]      req_rs1, req_rs2;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_op1, rsp_op2;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rf_reg_num;
  logic            rf_write;
  logic [XLEN-1:0] rf_wdata, rf_rdata;

  logic [XLEN-1:0] rf_mem [32];
  int vec_cnt = 0;
  int err_cnt = 0;

  regfile_port_sequencer #(.STARVE_LIMIT(STARVE_LIMIT), .XLEN(XLEN)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_reg_num(rf_reg_num), .rf_write(rf_write), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  assign rf_rdata = rf_mem[rf_reg_num];
  always @(posedge clk) if (rf_write) rf_mem[rf_reg_num] <= rf_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; rsp_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hdead;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    vec_cnt++; if (wb_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_wb_ready: got %b want 0", wb_ready); end
    vec_cnt++; if (rf_write !== 1'b0) begin err_cnt++; $display("FAIL rst_rf_write: got %b want 0", rf_write); end
    vec_cnt++; if (rf_reg_num !== 5'd0) begin err_cnt++; $display("FAIL rst_rf_reg_num: got %0d want 0", rf_reg_num); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    vec_cnt++; if (rsp_op1 !== 64'h0 || rsp_op2 !== 64'h0) begin err_cnt++; $display("FAIL rst_ops: got %h/%h want 0/0", rsp_op1, rsp_op2); end
    req_valid = 1'b0; wb_valid = 1'b0;
    resetn = 1'b1;
    tick();
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL post_rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_preload();
    logic [4:0]      rds [3];
    logic [XLEN-1:0] vals [3];
    rds[0] = 5'd5; rds[1] = 5'd6; rds[2] = 5'd7;
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h7;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_rd = rds[i]; wb_data = vals[i];
      #1;
      vec_cnt++; if (wb_ready !== 1'b1 || rf_write !== 1'b1 || rf_reg_num !== rds[i])
        begin err_cnt++; $display("FAIL preload_port x%0d: got rdy=%b wr=%b num=%0d want 1/1/%0d", rds[i], wb_ready, rf_write, rf_reg_num, rds[i]); end
      tick();
      vec_cnt++; if (rf_mem[rds[i]] !== vals[i]) begin err_cnt++; $display("FAIL preload_mem x%0d: got %h want %h", rds[i], rf_mem[rds[i]], vals[i]); end
    end
    wb_valid = 1'b0;
  endtask

  task automatic test_basic_read();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    #1;
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_accept: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rf_reg_num !== 5'd5 || rf_write !== 1'b0)
      begin err_cnt++; $display("FAIL basic_rd1: got v=%b rr=%b num=%0d wr=%b want 0/0/5/0", rsp_valid, req_ready, rf_reg_num, rf_write); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b0 || rf_reg_num !== 5'd6 || rf_write !== 1'b0)
      begin err_cnt++; $display("FAIL basic_rd2: got v=%b num=%0d wr=%b want 0/6/0", rsp_valid, rf_reg_num, rf_write); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'h11 || rsp_op2 !== 64'h22)
      begin err_cnt++; $display("FAIL basic_resp: got v=%b %h/%h want 1 11/22", rsp_valid, rsp_op1, rsp_op2); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin err_cnt++; $display("FAIL basic_done: got v=%b rr=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_x0();
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd7;
    tick();
    req_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
    #1;
    vec_cnt++; if (wb_ready !== 1'b1 || rf_write !== 1'b1 || rf_reg_num !== 5'd9)
      begin err_cnt++; $display("FAIL x0_rd1_wb: got rdy=%b wr=%b num=%0d want 1/1/9", wb_ready, rf_write, rf_reg_num); end
    tick();
    wb_valid = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || rf_reg_num !== 5'd7)
      begin err_cnt++; $display("FAIL x0_rd2: got v=%b num=%0d want 0/7", rsp_valid, rf_reg_num); end
    tick();
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'h0 || rsp_op2 !== 64'h7)
      begin err_cnt++; $display("FAIL x0_resp: got v=%b %h/%h want 1 0/7", rsp_valid, rsp_op1, rsp_op2); end
    vec_cnt++; if (rf_mem[9] !== 64'h99) begin err_cnt++; $display("FAIL x0_wb_mem: got %h want 99", rf_mem[9]); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_starve();
    logic       exp_rdy;
    logic [4:0] exp_num;
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10;
    for (int i = 0; i < 10; i++) begin
      wb_data = 64'h100 + 64'(i);
      #1;
      exp_rdy = ((i % 5) != 4);
      exp_num = exp_rdy ? 5'd10 : ((i < 5) ? 5'd5 : 5'd6);
      vec_cnt++; if (wb_ready !== exp_rdy || rf_reg_num !== exp_num || rf_write !== exp_rdy)
        begin err_cnt++; $display("FAIL starve_cyc%0d: got rdy=%b num=%0d wr=%b want %b/%0d/%b", i, wb_ready, rf_reg_num, rf_write, exp_rdy, exp_num, exp_rdy); end
      tick();
    end
    wb_valid = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'h11 || rsp_op2 !== 64'h22)
      begin err_cnt++; $display("FAIL starve_resp: got v=%b %h/%h want 1 11/22", rsp_valid, rsp_op1, rsp_op2); end
    vec_cnt++; if (rf_mem[10] !== 64'h108) begin err_cnt++; $display("FAIL starve_last_wb: got %h want 108", rf_mem[10]); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_dup_read();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd5;
    tick();
    req_valid = 1'b0;
    #1;
    vec_cnt++; if (rf_reg_num !== 5'd5 || rf_write !== 1'b0)
      begin err_cnt++; $display("FAIL dup_rd1: got num=%0d wr=%b want 5/0", rf_reg_num, rf_write); end
    tick();
`ifndef RFSEQ_DUP_READ_EN
    vec_cnt++; if (rsp_valid !== 1'b0 || rf_reg_num !== 5'd5)
      begin err_cnt++; $display("FAIL dup_rd2: got v=%b num=%0d want 0/5", rsp_valid, rf_reg_num); end
    tick();
`endif
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'h11 || rsp_op2 !== 64'h11)
      begin err_cnt++; $display("FAIL dup_resp: got v=%b %h/%h want 1 11/11", rsp_valid, rsp_op1, rsp_op2); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_snoop();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hAA;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b1 || wb_ready !== 1'b1 || rf_write !== 1'b1)
      begin err_cnt++; $display("FAIL snoop_wb: got v=%b rdy=%b wr=%b want 1/1/1", rsp_valid, wb_ready, rf_write); end
    tick();
    wb_rd = 5'd0; wb_data = 64'h55;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'hAA || rsp_op2 !== 64'h22)
      begin err_cnt++; $display("FAIL snoop_op1: got v=%b %h/%h want 1 aa/22", rsp_valid, rsp_op1, rsp_op2); end
    vec_cnt++; if (wb_ready !== 1'b1 || rf_write !== 1'b0)
      begin err_cnt++; $display("FAIL snoop_x0_wb: got rdy=%b wr=%b want 1/0", wb_ready, rf_write); end
    tick();
    wb_valid = 1'b0;
    #1;
    vec_cnt++; if (rsp_op1 !== 64'hAA || rsp_op2 !== 64'h22)
      begin err_cnt++; $display("FAIL snoop_x0_ops: got %h/%h want aa/22", rsp_op1, rsp_op2); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // Same register on both operands: one write must update both.
    req_valid = 1'b1; req_rs1 = 5'd6; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0;
`ifdef RFSEQ_DUP_READ_EN
    tick();
`else
    repeat (2) tick();
`endif
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 64'hCC;
    tick();
    wb_valid = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_op1 !== 64'hCC || rsp_op2 !== 64'hCC)
      begin err_cnt++; $display("FAIL snoop_both: got v=%b %h/%h want 1 cc/cc", rsp_valid, rsp_op1, rsp_op2); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd6;
    tick();
    req_valid = 1'b0;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 64'h33;
    #2;
    resetn = 1'b0;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || wb_ready !== 1'b0 || req_ready !== 1'b0 || rf_write !== 1'b0)
      begin err_cnt++; $display("FAIL midrst_async: got v=%b wr=%b rr=%b rfw=%b want 0/0/0/0", rsp_valid, wb_ready, req_ready, rf_write); end
    tick();
    wb_valid = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
    vec_cnt++; if (req_ready !== 1'b1 || rsp_op1 !== 64'h0)
      begin err_cnt++; $display("FAIL midrst_release: got rr=%b op1=%h want 1/0", req_ready, rsp_op1); end
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL midrst_stale%0d: got %b want 0", i, rsp_valid); end
      tick();
    end
    vec_cnt++; if (rf_mem[11] !== 64'h0) begin err_cnt++; $display("FAIL midrst_no_wb: got %h want 0", rf_mem[11]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    test_reset();
    test_preload();
    test_basic_read();
    test_x0();
    test_starve();
    test_dup_read();
    test_snoop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
